// File: rtl/rtp_result_pkg.sv
// rtp_result_pkg: shared FSM state codes, result word type and miss marker for the result collector
//   IDLE/CLEAR/COLLECT/DONE : collector states
//   hit_t                   : 32-bit IEEE-754 hit distance
//   HIT_MISS                : +Inf, stored for rays that never reported
package rtp_result_pkg;
    typedef logic [31:0] hit_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] COLLECT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam hit_t HIT_MISS = 32'h7F80_0000;
endpackage

// File: rtl/rtp_result_collector_if.sv
// rtp_result_collector_if: per-ray result stream from the pipeline into the collector
//   in_valid/in_ready : handshake, transfer when both are high
//   in_ray_id         : 32-bit ray index
//   in_hitT           : IEEE-754 hit distance
interface rtp_result_collector_if;
    import rtp_result_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [31:0] in_ray_id;
    hit_t in_hitT;
    modport master (output in_valid, in_ray_id, in_hitT, input in_ready);
    modport slave (input in_valid, in_ray_id, in_hitT, output in_ready);
endinterface

// File: rtl/rtp_result_ram.sv
// rtp_result_ram: simple dual-port result RAM, one write port and one read-first registered read port
//   clock            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request, data on rdata_o one cycle later (old data on same-address write)
module rtp_result_ram
    import rtp_result_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW = 10
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  hit_t          wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output hit_t          rdata_o
);
    hit_t mem_q [DEPTH];
    hit_t rdata_q;
    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/rtp_result_collector.sv
// rtp_result_collector: stores per-ray hit results by ray_id, counts duplicates and out-of-range ids, flags frame completion
//   clock, reset (sync, active-high)
//   start       : clear RAM and bitmap, begin a new frame
//   rtp_finish  : pipeline finished, forces DONE
//   in_if       : result stream (slave side)
//   rd_en/rd_addr -> rd_valid/rd_data/rd_hit one cycle later
//   busy/done/incomplete, collected_cnt/dup_cnt/oob_cnt/frame_cycles : status and saturating counters
module rtp_result_collector
    import rtp_result_pkg::*;
#(
    parameter int NUM_RAYS = 1024,
    parameter int ID_W = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rtp_finish,
    rtp_result_collector_if.slave in_if,
    input  logic                  rd_en,
    input  logic [ID_W-1:0]       rd_addr,
    output hit_t                  rd_data,
    output logic                  rd_hit,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  incomplete,
    output logic [ID_W:0]         collected_cnt,
    output logic [31:0]           dup_cnt,
    output logic [31:0]           oob_cnt,
    output logic [63:0]           frame_cycles
);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_RAYS - 1);
    localparam logic [ID_W:0] FULL = (ID_W+1)'(NUM_RAYS);
    localparam logic [31:0] LIMIT = 32'(NUM_RAYS);
    logic [1:0] state_q, state_d;
    logic [ID_W-1:0] clr_addr_q, clr_addr_d;
    logic [ID_W:0] collected_cnt_q, collected_cnt_d;
    logic [31:0] dup_cnt_q, dup_cnt_d, oob_cnt_q, oob_cnt_d;
    logic [63:0] frame_cycles_q, frame_cycles_d;
    logic incomplete_q, incomplete_d;
    logic [NUM_RAYS-1:0] bitmap_q;
    logic rd_valid_q, rd_clr_q, rd_hit_q;
    hit_t ram_rd_data;
    logic in_clear, in_collect, accept, oob, dup, wr_new;
    logic [ID_W-1:0] id;
    assign in_clear = state_q == CLEAR;
    assign in_collect = state_q == COLLECT;
    assign id = in_if.in_ray_id[ID_W-1:0];
    assign accept = in_if.in_valid && in_collect;
    assign oob = in_if.in_ray_id >= LIMIT;
    assign dup = !oob && bitmap_q[id];
    assign wr_new = accept && !oob && !dup;
    always_comb begin
        state_d = state_q;
        clr_addr_d = in_clear ? clr_addr_q + ID_W'(1) : clr_addr_q;
        collected_cnt_d = collected_cnt_q + (ID_W+1)'(wr_new);
        dup_cnt_d = dup_cnt_q + 32'(accept && dup && !(&dup_cnt_q));
        oob_cnt_d = oob_cnt_q + 32'(accept && oob && !(&oob_cnt_q));
        frame_cycles_d = frame_cycles_q + 64'(in_collect && !(&frame_cycles_q));
        incomplete_d = incomplete_q;
        if (start) begin
            state_d = CLEAR;
            clr_addr_d = '0;
            collected_cnt_d = '0;
            dup_cnt_d = '0;
            oob_cnt_d = '0;
            frame_cycles_d = '0;
            incomplete_d = 1'b0;
        end else if (in_clear && clr_addr_q == LAST) begin
            state_d = COLLECT;
        end else if (in_collect && (rtp_finish || collected_cnt_q == FULL)) begin
            state_d = DONE;
            // next-state count so a final write landing with rtp_finish still completes the frame
            incomplete_d = collected_cnt_d != FULL;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            clr_addr_q <= '0;
            collected_cnt_q <= '0;
            dup_cnt_q <= '0;
            oob_cnt_q <= '0;
            frame_cycles_q <= '0;
            incomplete_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_addr_q <= clr_addr_d;
            collected_cnt_q <= collected_cnt_d;
            dup_cnt_q <= dup_cnt_d;
            oob_cnt_q <= oob_cnt_d;
            frame_cycles_q <= frame_cycles_d;
            incomplete_q <= incomplete_d;
            rd_valid_q <= rd_en;
        end
    end
    // bitmap is only meaningful after a CLEAR pass, so it carries no reset
    always_ff @(posedge clock) begin
        if (in_clear) bitmap_q[clr_addr_q] <= 1'b0;
        else if (wr_new) bitmap_q[id] <= 1'b1;
        rd_hit_q <= bitmap_q[rd_addr];
        rd_clr_q <= in_clear;
    end
    rtp_result_ram #(.DEPTH(NUM_RAYS), .AW(ID_W)) u_ram (
        .clock   (clock),
        .we_i    (in_clear || wr_new),
        .waddr_i (in_clear ? clr_addr_q : id),
        .wdata_i (in_clear ? HIT_MISS : in_if.in_hitT),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (ram_rd_data)
    );
    assign in_if.in_ready = in_collect;
    assign busy = in_clear || in_collect;
    assign done = state_q == DONE;
    assign incomplete = incomplete_q;
    assign collected_cnt = collected_cnt_q;
    assign dup_cnt = dup_cnt_q;
    assign oob_cnt = oob_cnt_q;
    assign frame_cycles = frame_cycles_q;
    assign rd_valid = rd_valid_q;
    // reads issued during CLEAR report a miss regardless of the half-cleared contents
    assign rd_hit = rd_valid_q && !rd_clr_q && rd_hit_q;
    assign rd_data = !rd_valid_q ? '0 : rd_clr_q ? HIT_MISS : ram_rd_data;
endmodule

// File: doc/rtp_result_collector.md
# rtp_result_collector

Sink for the AO ray-tracing pipeline's per-ray result stream. It accepts (ray_id, hitT) results, stores them in a result RAM indexed by ray_id, and tracks duplicates and out-of-range ids. It raises done once every ray has reported or the pipeline signals finish. A readback port lets the testbench or host dump results after the run.

## Interface
Parameters:
- NUM_RAYS, 1024: rays per frame; result RAM depth.
- ID_W, 10: address width, equal to clog2(NUM_RAYS).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse: clear RAM and bitmap, begin a new frame.
- rtp_finish  in  1  pipeline finished; forces DONE.
- in_valid  in  1  result valid.
- in_ready  out  1  collector accepts this cycle.
- in_ray_id  in  32  ray index.
- in_hitT  in  32  IEEE-754 hit distance.
- rd_en  in  1  readback request.
- rd_addr  in  ID_W  readback index.
- rd_data  out  32  stored hitT.
- rd_hit  out  1  entry was written this frame.
- rd_valid  out  1  rd_data/rd_hit valid.
- busy  out  1  state is CLEAR or COLLECT.
- done  out  1  state is DONE.
- incomplete  out  1  DONE reached via rtp_finish with collected_cnt < NUM_RAYS.
- collected_cnt  out  ID_W+1  unique rays stored.
- dup_cnt  out  32  duplicate results dropped.
- oob_cnt  out  32  out-of-range ids dropped.
- frame_cycles  out  64  cycles spent in COLLECT.

## Operation
- States are IDLE, CLEAR, COLLECT and DONE. Reset enters IDLE.
- IDLE: start moves to CLEAR and zeroes all counters and the incomplete flag.
- CLEAR: clr_addr runs from 0 to NUM_RAYS-1, one entry per cycle. Each cycle writes HIT_MISS (32'h7F800000) to the RAM and clears the bitmap bit. After the last entry the state moves to COLLECT. CLEAR lasts exactly NUM_RAYS cycles.
- COLLECT: in_ready=1. On accept (in_valid && in_ready):
  - in_ray_id >= NUM_RAYS: drop the result, oob_cnt++.
  - bitmap[id] already set: drop the result, dup_cnt++. The first result is kept.
  - otherwise: write in_hitT to RAM[id], set bitmap[id], collected_cnt++.
- COLLECT, continued:
  - frame_cycles increments every cycle in COLLECT.
  - When collected_cnt reaches NUM_RAYS, the state moves to DONE on the following edge.
  - rtp_finish moves the state to DONE immediately. incomplete is set if collected_cnt < NUM_RAYS.
  - If the last unique write and rtp_finish arrive in the same cycle, the write is stored and incomplete=0.
- DONE: in_ready=0; counters hold. start moves to CLEAR.
- start in CLEAR or COLLECT restarts CLEAR from address 0 and zeroes the counters.
- Readback is legal in IDLE, COLLECT and DONE. In CLEAR, rd_valid is still produced but rd_hit=0 and rd_data=HIT_MISS.
- Counters saturate at their maximum value and never wrap.

## Timing
- Reset values: in_ready=0, busy=0, done=0, incomplete=0, rd_valid=0, rd_hit=0, rd_data=0, all counters 0. Reset mid-frame abandons RAM contents; the bitmap is not trusted until the next CLEAR.
- An accepted result updates the RAM, bitmap and counters at the same edge. The counter values are visible the next cycle.
- Readback latency is 1 cycle: rd_en at cycle t gives rd_valid=1 with data at t+1.
- A read and a write to the same address in the same cycle are read-first: the read returns the old data and old bitmap bit.
- in_ready is 0 during the CLEAR→COLLECT transition cycle's predecessor. It is 1 from the first COLLECT cycle onward.
- done asserts the cycle after the DONE transition condition.

## Structure
- Package rtp_result_pkg: state enum (IDLE, CLEAR, COLLECT, DONE) and the HIT_MISS constant.
- Sub-module rtp_result_ram: simple dual-port RAM, NUM_RAYS×32, one write port, one read-first registered read port. The bitmap stays in the collector as a flop vector.

## Test plan
- Reset, start, NUM_RAYS=16; send ids 0..15 with hitT=id → done=1, incomplete=0, collected_cnt=16, CLEAR took 16 cycles, readback of id 5 gives 32'h5 with rd_hit=1.
- Send id 3 twice (hitT 1.0 then 2.0) → dup_cnt=1, RAM[3]=32'h3F800000.
- Send id 20 with NUM_RAYS=16 → oob_cnt=1, no RAM write, collected_cnt unchanged.
- Send 10 unique ids, then rtp_finish → done=1, incomplete=1, unwritten entries read 32'h7F800000 with rd_hit=0.
- Issue rd_en on id 7 in the same cycle as a write to id 7 → old value returned, new value on the next read.
- Pulse start mid-COLLECT, then assert reset mid-CLEAR → counters cleared, state IDLE, all outputs at their reset values.
